// File: rtl/result_mem_writer_pkg.sv
// Shared definitions for the result memory writer: line geometry, tile size
// encoding and the job FSM states.
package result_mem_writer_pkg;

  localparam int DEFAULT_ELEM_W = 32;
  localparam int DEFAULT_ADDR_W = 8;
  localparam int LINE_W         = 512;
  localparam int TILE_DIM       = 4;
  localparam int LANE_W         = LINE_W / (TILE_DIM * TILE_DIM);
  localparam int SLOTS_PER_LINE = 4;
  localparam int SLOT_W         = LINE_W / SLOTS_PER_LINE;

  typedef enum logic {
    SIZE_4X4 = 1'b0,
    SIZE_2X2 = 1'b1
  } size_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_FLUSH,
    ST_DONE
  } state_e;

  typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/result_mem_writer_line_fifo.sv
// Small synchronous FIFO of packed output lines sitting between tile packing
// and the output SRAM write port.
module line_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: line storage is deliberately left unreset; the pointers and count
  // define validity, and consumers gate the head with empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/result_mem_writer.sv
// Collects 4x4 or 2x2 result tiles from the PE array, packs them into 512-bit
// lines and streams the lines to the output SRAM at consecutive addresses.
module result_mem_writer
  import result_mem_writer_pkg::*;
#(
  parameter int ELEM_W     = DEFAULT_ELEM_W,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start_i,
  input  logic [7:0]                         total_tiles_i,
  input  logic                               size_type_i,
  input  logic                               tile_valid_i,
  output logic                               tile_ready_o,
  input  logic signed [3:0][3:0][ELEM_W-1:0] result_tile_i,
  output logic                               mem_wr_en_o,
  input  logic                               mem_wr_ready_i,
  output logic [ADDR_W-1:0]                  mem_wr_addr_o,
  output logic [LINE_W-1:0]                  mem_wr_data_o,
  output logic                               busy_o,
  output logic                               write_done_o
);

  state_e            state;
  size_type_e        size_q;
  logic [7:0]        total_q;
  logic [7:0]        tile_cnt;
  line_t             pack_q;
  line_t             line_4x4;
  line_t             line_2x2;
  line_t             push_line;
  line_t             fifo_head;
  logic [SLOT_W-1:0] quad;
  logic [1:0]        slot;
  logic              accept;
  logic              last_tile;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  // Ready depends on registered state only, never on tile_valid_i.
  assign tile_ready_o = (state == ST_COLLECT) && !fifo_full;
  assign accept       = tile_valid_i && tile_ready_o;
  assign slot         = tile_cnt[1:0];
  assign last_tile    = (tile_cnt == total_q - 8'd1);
  assign push         = accept && ((size_q == SIZE_4X4) || (slot == 2'd3) || last_tile);
  assign pop          = mem_wr_en_o && mem_wr_ready_i;

  // NOTE: every always_comb output gets a default first so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    line_4x4 = '0;
    quad     = '0;
    line_2x2 = pack_q;
    for (int r = 0; r < TILE_DIM; r++) begin
      for (int c = 0; c < TILE_DIM; c++) begin
        line_4x4[(TILE_DIM*r + c)*LANE_W +: LANE_W] = LANE_W'($signed(result_tile_i[r][c]));
      end
    end
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        quad[(2*r + c)*LANE_W +: LANE_W] = LANE_W'($signed(result_tile_i[r][c]));
      end
    end
    // Slots above the current one are still zero, so a partial last line
    // goes out with its unused slots cleared.
    line_2x2[int'(slot)*SLOT_W +: SLOT_W] = quad;
    push_line = (size_q == SIZE_4X4) ? line_4x4 : line_2x2;
  end

  line_fifo #(
    .WIDTH (LINE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_line_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_line),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign mem_wr_en_o   = !fifo_empty;
  assign mem_wr_data_o = fifo_empty ? '0 : fifo_head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      size_q       <= SIZE_4X4;
      total_q      <= '0;
      tile_cnt     <= '0;
      pack_q       <= '0;
      busy_o       <= 1'b0;
      write_done_o <= 1'b0;
    end else begin
      write_done_o <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            total_q  <= total_tiles_i;
            size_q   <= size_type_e'(size_type_i);
            tile_cnt <= '0;
            pack_q   <= '0;
            busy_o   <= 1'b1;
            state    <= (total_tiles_i == 8'd0) ? ST_DONE : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            tile_cnt <= tile_cnt + 8'd1;
            if (size_q == SIZE_2X2) pack_q <= push ? '0 : line_2x2;
            if (last_tile) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (fifo_empty) state <= ST_DONE;
        end
        ST_DONE: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Line address restarts with every job and advances once per completed write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wr_addr_o <= '0;
    end else if ((state == ST_IDLE) && start_i) begin
      mem_wr_addr_o <= '0;
    end else if (pop) begin
      mem_wr_addr_o <= mem_wr_addr_o + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_result_mem_writer.sv
// Self-checking bench for result_mem_writer: table of jobs, hand-written
// corner sequences and random jobs, scored against a line-level model.
module tb_result_mem_writer;

  localparam int TB_ADDR_W  = 3;
  localparam int ADDR_SPAN  = 1 << TB_ADDR_W;
  localparam int FIFO_DEPTH = 2;
  localparam int JOB_BUDGET = 600;

  typedef logic [511:0]          line_t;
  typedef logic [3:0][3:0][31:0] tile_t;

  typedef struct {
    logic size;
    int   total;
    int   ready_pct;
    int   tile_pct;
    int   stall;
    bit   fill_seq;
    bit   glitch;
    int   exp_writes;
  } job_vec_t;

  logic                         clk;
  logic                         rst_n;
  logic                         start_i;
  logic [7:0]                   total_tiles_i;
  logic                         size_type_i;
  logic                         tile_valid_i;
  logic                         tile_ready_o;
  logic signed [3:0][3:0][31:0] result_tile_i;
  logic                         mem_wr_en_o;
  logic                         mem_wr_ready_i;
  logic [TB_ADDR_W-1:0]         mem_wr_addr_o;
  line_t                        mem_wr_data_o;
  logic                         busy_o;
  logic                         write_done_o;

  int       n_compared;
  int       n_mismatched;
  int       done_count;
  int       wr_en_seen;
  tile_t    acc_q[$];
  int       wr_addr_q[$];
  line_t    wr_data_q[$];
  job_vec_t vecs[8];

  result_mem_writer #(
    .ELEM_W     (32),
    .ADDR_W     (TB_ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .start_i        (start_i),
    .total_tiles_i  (total_tiles_i),
    .size_type_i    (size_type_i),
    .tile_valid_i   (tile_valid_i),
    .tile_ready_o   (tile_ready_o),
    .result_tile_i  (result_tile_i),
    .mem_wr_en_o    (mem_wr_en_o),
    .mem_wr_ready_i (mem_wr_ready_i),
    .mem_wr_addr_o  (mem_wr_addr_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .busy_o         (busy_o),
    .write_done_o   (write_done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Observe handshakes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tile_valid_i && tile_ready_o) acc_q.push_back(result_tile_i);
      if (mem_wr_en_o && mem_wr_ready_i) begin
        wr_addr_q.push_back(int'(mem_wr_addr_o));
        wr_data_q.push_back(mem_wr_data_o);
      end
      if (mem_wr_en_o)  wr_en_seen++;
      if (write_done_o) done_count++;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_compared++;
    if (got != exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_line(input string name, input line_t got, input line_t exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic tile_t make_tile(input bit seq);
    tile_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = seq ? 32'(4*r + c + 1) : $urandom();
    return t;
  endfunction

  // Reference lines built from the accepted tiles and the layout rules.
  function automatic void build_model(input logic size, output line_t lines[$]);
    line_t l;
    int    n;
    lines.delete();
    n = acc_q.size();
    if (size == 1'b0) begin
      for (int t = 0; t < n; t++) begin
        l = '0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            l[(4*r + c)*32 +: 32] = acc_q[t][r][c];
        lines.push_back(l);
      end
    end else begin
      for (int t = 0; t < n; t += 4) begin
        l = '0;
        for (int k = 0; k < 4; k++)
          if (t + k < n)
            for (int r = 0; r < 2; r++)
              for (int c = 0; c < 2; c++)
                l[k*128 + (2*r + c)*32 +: 32] = acc_q[t+k][r][c];
        lines.push_back(l);
      end
    end
  endfunction

  task automatic run_job(input job_vec_t v, input string tag);
    int    cyc;
    int    n;
    int    last_n;
    int    head_addr;
    bit    holding;
    bit    seen_done;
    bit    stable_ok;
    bit    have_head;
    line_t head_data;
    line_t exp_q[$];
    acc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_count    = 0;
    start_i       = 1'b1;
    total_tiles_i = 8'(v.total);
    size_type_i   = v.size;
    @(posedge clk); #1;
    start_i       = 1'b0;
    total_tiles_i = 8'(v.total + 7);
    size_type_i   = ~v.size;
    check({tag, " busy after start"}, int'(busy_o), 1);
    cyc = 0; last_n = 0; holding = 1'b0; seen_done = 1'b0;
    stable_ok = 1'b1; have_head = 1'b0; head_addr = 0; head_data = '0;
    while (!seen_done && cyc < JOB_BUDGET) begin
      if (write_done_o) begin
        seen_done = 1'b1;
      end else begin
        if (v.stall > 0 && cyc == v.stall) begin
          check({tag, " tiles taken before fifo full"}, acc_q.size(), FIFO_DEPTH);
          check({tag, " tile_ready while fifo full"}, int'(tile_ready_o), 0);
          check({tag, " head stable during stall"}, int'(stable_ok && have_head), 1);
        end
        if (cyc < v.stall && mem_wr_en_o) begin
          if (!have_head) begin
            have_head = 1'b1;
            head_addr = int'(mem_wr_addr_o);
            head_data = mem_wr_data_o;
          end else if (int'(mem_wr_addr_o) != head_addr || mem_wr_data_o !== head_data) begin
            stable_ok = 1'b0;
          end
        end
        n = acc_q.size();
        if (holding && n > last_n) holding = 1'b0;
        last_n = n;
        if (!holding) begin
          if (n < v.total && int'($urandom_range(99)) < v.tile_pct) begin
            result_tile_i = make_tile(v.fill_seq);
            tile_valid_i  = 1'b1;
            holding       = 1'b1;
          end else begin
            tile_valid_i = 1'b0;
          end
        end
        mem_wr_ready_i = (cyc < v.stall) ? 1'b0 : (int'($urandom_range(99)) < v.ready_pct);
        start_i        = v.glitch && (cyc == 1);
        @(posedge clk); #1;
        cyc++;
      end
    end
    tile_valid_i   = 1'b0;
    mem_wr_ready_i = 1'b0;
    start_i        = 1'b0;
    check({tag, " write_done within budget"}, int'(seen_done), 1);
    repeat (2) begin @(posedge clk); #1; end
    check({tag, " write_done pulses"}, done_count, 1);
    check({tag, " busy after done"}, int'(busy_o), 0);
    check({tag, " tiles accepted"}, acc_q.size(), v.total);
    check({tag, " line writes"}, wr_data_q.size(), v.exp_writes);
    build_model(v.size, exp_q);
    for (int i = 0; i < wr_data_q.size() && i < exp_q.size(); i++) begin
      check_line($sformatf("%s line %0d data", tag, i), wr_data_q[i], exp_q[i]);
      check($sformatf("%s line %0d addr", tag, i), wr_addr_q[i], i % ADDR_SPAN);
    end
  endtask

  initial begin
    int       n;
    line_t    tmp;
    job_vec_t v;

    n_compared = 0; n_mismatched = 0; done_count = 0; wr_en_seen = 0;
    start_i = 1'b0; total_tiles_i = '0; size_type_i = 1'b0;
    tile_valid_i = 1'b0; mem_wr_ready_i = 1'b0; result_tile_i = '0;

    //           size  total rdy%  tile% stall seq   glitch writes
    vecs[0] = '{1'b0,  3,    100,  100,  0,    1'b1, 1'b0,  3};
    vecs[1] = '{1'b1,  5,    100,  100,  0,    1'b0, 1'b0,  2};
    vecs[2] = '{1'b0,  4,    100,  100,  10,   1'b0, 1'b0,  4};
    vecs[3] = '{1'b1,  8,    50,   70,   0,    1'b0, 1'b1,  2};
    vecs[4] = '{1'b0,  6,    30,   100,  0,    1'b0, 1'b1,  6};
    vecs[5] = '{1'b1,  1,    100,  100,  0,    1'b0, 1'b0,  1};
    vecs[6] = '{1'b1,  4,    20,   100,  0,    1'b0, 1'b0,  1};
    vecs[7] = '{1'b0,  12,   70,   90,   0,    1'b0, 1'b0,  12};

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset tile_ready", int'(tile_ready_o), 0);
    check("reset mem_wr_en", int'(mem_wr_en_o), 0);
    check("reset busy", int'(busy_o), 0);
    check("reset write_done", int'(write_done_o), 0);
    check("reset addr", int'(mem_wr_addr_o), 0);
    check_line("reset data", mem_wr_data_o, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i], $sformatf("vec%0d", i));
      if (i == 0 && wr_data_q.size() > 0) begin
        tmp = wr_data_q[0];
        check("vec0 lane 15 value", int'(tmp[15*32 +: 32]), 16);
      end
      if (i == 1 && wr_data_q.size() > 1) begin
        tmp = wr_data_q[1];
        check("vec1 unused slots set bits", $countones(tmp[511:128]), 0);
      end
    end

    // Empty job: straight to DONE, no writes.
    wr_en_seen = 0; done_count = 0;
    start_i = 1'b1; total_tiles_i = 8'd0; size_type_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 1;
    while (!write_done_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("zero job done latency", n, 2);
    repeat (2) begin @(posedge clk); #1; end
    check("zero job write enables", wr_en_seen, 0);
    check("zero job done pulses", done_count, 1);

    // Abort a job with two lines buffered.
    acc_q.delete(); done_count = 0;
    start_i = 1'b1; total_tiles_i = 8'd4; size_type_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0; mem_wr_ready_i = 1'b0;
    result_tile_i = make_tile(1'b0); tile_valid_i = 1'b1;
    n = 0;
    while (n < 20 && !(mem_wr_en_o && !tile_ready_o)) begin
      @(posedge clk); #1;
      if (tile_valid_i && acc_q.size() > 0) result_tile_i = make_tile(1'b0);
      n++;
    end
    check("abort lines buffered", acc_q.size(), FIFO_DEPTH);
    #3 rst_n = 1'b0;
    #1;
    check("abort mem_wr_en", int'(mem_wr_en_o), 0);
    check_line("abort data", mem_wr_data_o, '0);
    check("abort addr", int'(mem_wr_addr_o), 0);
    check("abort busy", int'(busy_o), 0);
    check("abort tile_ready", int'(tile_ready_o), 0);
    tile_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("abort write_done pulses", done_count, 0);

    for (int j = 0; j < 10; j++) begin
      v.size       = 1'($urandom_range(1));
      v.total      = int'($urandom_range(12, 1));
      v.ready_pct  = int'($urandom_range(100, 20));
      v.tile_pct   = int'($urandom_range(100, 30));
      v.stall      = 0;
      v.fill_seq   = 1'b0;
      v.glitch     = (v.total >= 3) && ($urandom_range(1) == 1);
      v.exp_writes = v.size ? (v.total + 3) / 4 : v.total;
      run_job(v, $sformatf("rnd%0d", j));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/result_mem_writer.md
RESULT_MEM_WRITER -- requirements
Module: result_mem_writer

Interface
REQ-001 Parameter: ELEM_W, default 32, width of one signed output element.
REQ-002 Parameter: ADDR_W, default 8, output memory line address width.
REQ-003 Parameter: FIFO_DEPTH, default 2, number of 512-bit lines buffered toward memory.
REQ-004 Port: clk  in  1  single clock; all state on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: start_i  in  1  one-cycle pulse from main controller; begins a job.
REQ-007 Port: total_tiles_i  in  8  number of tiles in the job; sampled on accepted start_i.
REQ-008 Port: size_type_i  in  1  sampled on accepted start_i; 0 = 4x4 output tile, 1 = 2x2 output tile.
REQ-009 Port: tile_valid_i  in  1  PE array presents a tile.
REQ-010 Port: tile_ready_o  out  1  block accepts the tile this cycle.
REQ-011 Port: result_tile_i  in  signed ELEM_W x [3:0][3:0]  output tile; only [1:0][1:0] used in 2x2 mode.
REQ-012 Port: mem_wr_en_o  out  1  write request to output SRAM.
REQ-013 Port: mem_wr_ready_i  in  1  SRAM accepts the write this cycle.
REQ-014 Port: mem_wr_addr_o  out  ADDR_W  line address.
REQ-015 Port: mem_wr_data_o  out  512  packed line.
REQ-016 Port: busy_o  out  1  job in progress.
REQ-017 Port: write_done_o  out  1  one-cycle pulse; job fully written.

Function
REQ-018 FSM states: IDLE, COLLECT, FLUSH, DONE; IDLE->COLLECT on start_i; start_i ignored outside IDLE.
REQ-019 total_tiles_i = 0 on start: IDLE->DONE directly; no memory writes.
REQ-020 Tile handshake: transfer when tile_valid_i && tile_ready_o; tile_ready_o = (state==COLLECT) && line FIFO not full; no combinational path from tile_valid_i to tile_ready_o.
REQ-021 4x4 mode: each tile forms one line; element (r,c) at bits [(4r+c)*32 +: 32].
REQ-022 2x2 mode: four tiles per line; tile slot k (0..3, arrival order) at bits [k*128 +: 128], element (r,c) at slot offset (2r+c)*32.
REQ-023 Line pushed to FIFO in the cycle after its last tile is accepted; a final partial 2x2 line is pushed with unused slots zero.
REQ-024 After the last tile is accepted: COLLECT->FLUSH; FLUSH->DONE when FIFO is empty and no write is pending; DONE lasts one cycle, asserts write_done_o, then ->IDLE.
REQ-025 mem_wr_en_o = FIFO non-empty; data/address held stable until mem_wr_ready_i; pop on mem_wr_en_o && mem_wr_ready_i.
REQ-026 Line address starts at 0 each job, +1 per completed write, wraps 2^ADDR_W-1 -> 0.
REQ-027 Latency: 4x4 tile accepted in cycle N -> mem_wr_en_o high in N+1 if FIFO was empty.
REQ-028 Simultaneous push and pop on a full FIFO is not permitted; tile_ready_o stays low while full.
REQ-029 busy_o high in COLLECT, FLUSH, DONE.

Reset
REQ-030 Asynchronous assertion: state IDLE, FIFO empty, counters 0, pack register 0; tile_ready_o, mem_wr_en_o, busy_o, write_done_o 0; mem_wr_addr_o 0; mem_wr_data_o 0.
REQ-031 Reset mid-job discards buffered lines; no write_done_o is generated for the aborted job.

Structure
REQ-032 Shared package holds ELEM_W, LINE_W=512, ADDR_W defaults, the size_type encoding and the FSM state enum.
REQ-033 One sub-module, line_fifo (parameterised depth/width, full/empty flags), instantiated once.

Verification
REQ-034 4x4 mode, total=3, mem_wr_ready_i always 1, tiles filled with 1..16 -> three writes to addresses 0,1,2, element (r,c) value 4r+c+1 at lane 4r+c, one write_done_o pulse.
REQ-035 2x2 mode, total=5 -> two writes: addr 0 carries 4 tiles; addr 1 carries tile 4 in slot 0 with slots 1-3 zero.
REQ-036 mem_wr_ready_i held 0 for 10 cycles, 4x4 mode -> FIFO fills after 2 tiles, tile_ready_o drops, addr/data stable, no data lost after release.
REQ-037 total=0 -> no mem_wr_en_o; write_done_o exactly two cycles after start_i.
REQ-038 reset asserted while the FIFO holds 2 lines -> all outputs 0 immediately; new job restarts at address 0.
REQ-039 start_i pulsed during COLLECT -> ignored; tile count and size_type unchanged.
